corral_autoplayer: RTL
======================

# corral_autoplayer

Host-side automated player for the corral game: the opposite end of the game pin interface. It drives `enter`/`move` into the game core and reads back the per-turn status frame (`ready`, `gameover`, `lostwon`, `data` nibbles). Each turn it captures the cowboy and horse positions, picks a chase move, and issues it, until the game ends, a move limit is hit, or the game stops responding. It sits beside the game top level on the board or in the bench.

## Interface
- `MAX_MOVES`, default 63: move budget per game, range 1..255; reaching it without gameover ends the game as lost.
- `TIMEOUT_CYCLES`, default 255: watchdog limit for waiting on a frame, range 2..65535; only used when `CORRAL_AUTOPLAYER_TIMEOUT_EN` is defined.

Ports:
- `clock` in 1: clock; all logic on the rising edge.
- `reset_n` in 1: synchronous, active-low reset.
- `start` in 1: request a new game; sampled only in IDLE or DONE.
- `game_ready` in 1: frame strobe from game; the cycle it is high, `game_data` holds the cowboy position.
- `game_data` in 4: position nibble {row[1:0], col[1:0]}; holds the horse position the cycle after `game_ready`.
- `game_gameover` in 1: valid in the `game_ready` cycle.
- `game_lostwon` in 1: valid in the `game_ready` cycle; 1 means won.
- `game_enter` out 1: one-cycle move strobe to the game.
- `game_move` out 3: move code, valid only when `game_enter` is 1, 0 otherwise.
- `busy` out 1: high from game start until DONE.
- `done` out 1: high while in DONE.
- `won` out 1: result of the last game.
- `timed_out` out 1: last game ended by the watchdog.
- `move_count` out 8: moves issued in the current or last game.
- `cowboy_pos` out 4: last captured cowboy position.
- `horse_pos` out 4: last captured horse position.

## Operation
- Move codes:
  - 0 = stay/start
  - 1 = up (row−1)
  - 2 = down (row+1)
  - 3 = left (col−1)
  - 4 = right (col+1)
  - 5–7 are never issued.
- States:
  - IDLE: leaves on `start`=1. Clears `move_count`, `won`, `timed_out`; goes to START.
  - START: `game_enter`=1 with move 0 for one cycle; goes to WAIT_C.
  - WAIT_C: stays until `game_ready`=1. Then latches `cowboy_pos`←`game_data` and latches gameover/lostwon; goes to WAIT_H.
  - WAIT_H: latches `horse_pos`←`game_data` unconditionally. Goes to DONE if the latched gameover is 1, else to DECIDE.
  - DECIDE: if `move_count`==MAX_MOVES, goes to DONE with `won`=0. Otherwise computes the move and goes to ISSUE.
  - ISSUE: `game_enter`=1 with the computed move for one cycle; `move_count` increments; goes to WAIT_C.
  - DONE: `done`=1. On `start`=1, goes to START with counters cleared as in IDLE.
- Chase policy, from the latched positions:
  - if cowboy row < horse row: down
  - else if cowboy row > horse row: up
  - else if cowboy col < horse col: right
  - else if cowboy col > horse col: left
  - else (positions equal): stay (0)
- Never issues a move that would leave the 4x4 grid; the policy guarantees this by construction.
- On gameover, `won`←latched lostwon.
- `move_count` saturates at MAX_MOVES and never wraps.
- `game_ready` seen outside WAIT_C is ignored (no capture, no state change).
- `start` is ignored while `busy`=1.

## Timing
- Reset values (registered, cleared when `reset_n`=0 at an edge):
  - outputs: `game_enter`=0, `game_move`=0, `busy`=0, `done`=0, `won`=0, `timed_out`=0, `move_count`=0, `cowboy_pos`=0, `horse_pos`=0
  - state: IDLE
- Reset mid-game takes effect at that edge: `game_enter` is low the following cycle and no partial move is emitted.
- Outputs are registered:
  - `start` sampled at edge T gives `game_enter`=1 during cycle T+1.
  - `game_ready` sampled at edge N gives horse captured at N+1, DECIDE at N+2, and `game_enter`=1 during cycle N+3.
- Exactly one `game_enter` pulse per turn; never two consecutive cycles.
- `done` rises the cycle after WAIT_H sees gameover, or after DECIDE sees the limit.

## Configuration
- Macro: `CORRAL_AUTOPLAYER_TIMEOUT_EN`.
- Defined:
  - A 16-bit watchdog counts cycles spent in WAIT_C and resets on entering WAIT_C.
  - When the count reaches TIMEOUT_CYCLES with no `game_ready`, the block goes to DONE with `timed_out`=1 and `won`=0.
- Undefined:
  - No counter is built and WAIT_C waits forever.
  - `timed_out` is tied to 0.

## Test plan
- Reset then idle: all outputs 0, state IDLE. With `start` held 0 for 20 cycles, `game_enter` never rises.
- Start handshake: `start` pulse gives `game_enter`=1 and `game_move`=0 for exactly one cycle, and `busy`=1.
- Chase turn: frame cowboy=0x0, horse=0xA, gameover=0 → `game_enter` 3 cycles after `game_ready` with move 2 (down). `move_count`=1.
- Game won: frame with gameover=1, lostwon=1, cowboy=0x5, horse=0x5 → `done`=1, `won`=1, no `game_enter`. A following `start` begins a new game with `move_count`=0.
- Move limit: MAX_MOVES=3, game never ends → exactly 3 move strobes, then `done`=1 and `won`=0.
- Timeout (macro defined, TIMEOUT_CYCLES=10): no `game_ready` after start → `done`=1 and `timed_out`=1 ten cycles into WAIT_C. With the macro undefined, `busy` stays 1 indefinitely.

Source files
------------

// File: rtl/corral_autoplayer.sv
// rtl/corral_autoplayer.sv - automated chase player driving the corral game pin interface
// Optional watchdog on frame waits: define CORRAL_AUTOPLAYER_TIMEOUT_EN.
module corral_autoplayer #(
    parameter int MAX_MOVES      = 63,
    parameter int TIMEOUT_CYCLES = 255
) (
    input  logic       clock,
    input  logic       reset_n,
    input  logic       start,
    input  logic       game_ready,
    input  logic [3:0] game_data,
    input  logic       game_gameover,
    input  logic       game_lostwon,
    output logic       game_enter,
    output logic [2:0] game_move,
    output logic       busy,
    output logic       done,
    output logic       won,
    output logic       timed_out,
    output logic [7:0] move_count,
    output logic [3:0] cowboy_pos,
    output logic [3:0] horse_pos
);

    localparam logic [7:0] LP_MAX_MOVES = 8'(MAX_MOVES);

    localparam logic [2:0] MV_STAY  = 3'd0;
    localparam logic [2:0] MV_UP    = 3'd1;
    localparam logic [2:0] MV_DOWN  = 3'd2;
    localparam logic [2:0] MV_LEFT  = 3'd3;
    localparam logic [2:0] MV_RIGHT = 3'd4;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_START,
        ST_WAIT_C,
        ST_WAIT_H,
        ST_DECIDE,
        ST_ISSUE,
        ST_DONE
    } state_t;

    state_t     r_state;
    state_t     w_next_state;
    logic       r_game_enter;
    logic [2:0] r_game_move;
    logic       r_busy;
    logic       r_done;
    logic       r_won;
    logic       r_timed_out;
    logic [7:0] r_move_count;
    logic [3:0] r_cowboy_pos;
    logic [3:0] r_horse_pos;
    logic       r_gameover;
    logic       r_lostwon;
    logic [2:0] w_move;
    logic       w_new_game;
    logic       w_timeout;

`ifdef CORRAL_AUTOPLAYER_TIMEOUT_EN
    localparam logic [15:0] LP_WD_LAST = 16'(TIMEOUT_CYCLES - 1);
    logic [15:0] r_wd_count;
    assign w_timeout = (r_state == ST_WAIT_C) && !game_ready && (r_wd_count == LP_WD_LAST);
`else
    assign w_timeout = 1'b0;
`endif

    assign w_new_game = ((r_state == ST_IDLE) || (r_state == ST_DONE)) && start;

    // Close rows first, then columns; each step moves toward an on-grid target, so it stays on-grid.
    always_comb begin
        w_move = MV_STAY;
        if (r_cowboy_pos[3:2] < r_horse_pos[3:2])
            w_move = MV_DOWN;
        else if (r_cowboy_pos[3:2] > r_horse_pos[3:2])
            w_move = MV_UP;
        else if (r_cowboy_pos[1:0] < r_horse_pos[1:0])
            w_move = MV_RIGHT;
        else if (r_cowboy_pos[1:0] > r_horse_pos[1:0])
            w_move = MV_LEFT;
    end

    always_comb begin
        w_next_state = r_state;
        case (r_state)
            ST_IDLE:   if (start) w_next_state = ST_START;
            ST_START:  w_next_state = ST_WAIT_C;
            ST_WAIT_C: begin
                if (game_ready)
                    w_next_state = ST_WAIT_H;
                else if (w_timeout)
                    w_next_state = ST_DONE;
            end
            ST_WAIT_H: w_next_state = r_gameover ? ST_DONE : ST_DECIDE;
            ST_DECIDE: w_next_state = (r_move_count == LP_MAX_MOVES) ? ST_DONE : ST_ISSUE;
            ST_ISSUE:  w_next_state = ST_WAIT_C;
            ST_DONE:   if (start) w_next_state = ST_START;
            default:   w_next_state = ST_IDLE;
        endcase
    end

    always_ff @(posedge clock) begin
        if (!reset_n) begin
            r_state      <= ST_IDLE;
            r_game_enter <= 1'b0;
            r_game_move  <= MV_STAY;
            r_busy       <= 1'b0;
            r_done       <= 1'b0;
            r_won        <= 1'b0;
            r_timed_out  <= 1'b0;
            r_move_count <= 8'd0;
            r_cowboy_pos <= 4'd0;
            r_horse_pos  <= 4'd0;
            r_gameover   <= 1'b0;
            r_lostwon    <= 1'b0;
        end else begin
            r_state      <= w_next_state;
            // Strobe outputs are decoded from the next state so they line up with START/ISSUE.
            r_game_enter <= (w_next_state == ST_START) || (w_next_state == ST_ISSUE);
            r_game_move  <= (w_next_state == ST_ISSUE) ? w_move : MV_STAY;
            r_busy       <= (w_next_state != ST_IDLE) && (w_next_state != ST_DONE);
            r_done       <= (w_next_state == ST_DONE);

            if (w_new_game) begin
                r_move_count <= 8'd0;
                r_won        <= 1'b0;
                r_timed_out  <= 1'b0;
            end
            if ((r_state == ST_WAIT_C) && game_ready) begin
                r_cowboy_pos <= game_data;
                r_gameover   <= game_gameover;
                r_lostwon    <= game_lostwon;
            end
            if (r_state == ST_WAIT_H) begin
                r_horse_pos <= game_data;
                if (r_gameover)
                    r_won <= r_lostwon;
            end
            if ((r_state == ST_DECIDE) && (w_next_state == ST_ISSUE) && (r_move_count != 8'hFF))
                r_move_count <= r_move_count + 8'd1;
            if (w_timeout) begin
                r_timed_out <= 1'b1;
                r_won       <= 1'b0;
            end
        end
    end

`ifdef CORRAL_AUTOPLAYER_TIMEOUT_EN
    always_ff @(posedge clock) begin
        if (!reset_n || (r_state != ST_WAIT_C))
            r_wd_count <= 16'd0;
        else if (!game_ready)
            r_wd_count <= r_wd_count + 16'd1;
    end
`endif

    assign game_enter = r_game_enter;
    assign game_move  = r_game_move;
    assign busy       = r_busy;
    assign done       = r_done;
    assign won        = r_won;
    assign timed_out  = r_timed_out;
    assign move_count = r_move_count;
    assign cowboy_pos = r_cowboy_pos;
    assign horse_pos  = r_horse_pos;

endmodule
